// File: rtl/misr_response_analyzer_if.sv
// Response stream from the core under test into the MISR analyzer.
// The core side drives RESP/RESP_VALID and the analyzer returns RESP_READY.
interface misr_response_analyzer_if #(
    parameter int WIDTH = 19
);
    logic [WIDTH-1:0] RESP;
    logic             RESP_VALID;
    logic             RESP_READY;

    modport master (output RESP, output RESP_VALID, input RESP_READY);
    modport slave  (input RESP, input RESP_VALID, output RESP_READY);
endinterface

// File: rtl/misr_response_analyzer.sv
// Compacts NUM_PAT response beats into a Galois MISR, then compares the
// final signature against GOLDEN in a single CMP cycle.
module misr_response_analyzer #(
    parameter int               WIDTH   = 19,
    parameter logic [WIDTH-1:0] POLY    = 19'h00027,
    parameter logic [WIDTH-1:0] SEED    = '0,
    parameter int               COUNT_W = 16
) (
    input  logic                CK,
    input  logic                RST_N,
    input  logic                START,
    input  logic [COUNT_W-1:0]  NUM_PAT,
    input  logic [WIDTH-1:0]    GOLDEN,
    misr_response_analyzer_if.slave rsp,
    output logic                BUSY,
    output logic                DONE,
    output logic                PASS,
    output logic [WIDTH-1:0]    SIGNATURE
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_CMP} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   misr_q, misr_d, misr_nxt;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               accept;

    assign accept = (state_q == S_RUN) && rsp.RESP_VALID;

    // Galois step: the MSB folds back through the taps; bit 0 always takes feedback.
    always_comb begin
        misr_nxt    = '0;
        misr_nxt[0] = misr_q[WIDTH-1] ^ rsp.RESP[0];
        for (int i = 1; i < WIDTH; i++)
            misr_nxt[i] = misr_q[i-1] ^ (POLY[i] & misr_q[WIDTH-1]) ^ rsp.RESP[i];
    end

    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            misr_q  <= SEED;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            misr_q  <= misr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        misr_d  = misr_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        pass_d  = pass_q;
        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    misr_d = SEED;
                    done_d = 1'b0;
                    pass_d = 1'b0;
                    if (NUM_PAT == '0) begin
                        state_d = S_CMP;
                    end else begin
                        cnt_d   = NUM_PAT;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (accept) begin
                    misr_d = misr_nxt;
                    cnt_d  = cnt_q - COUNT_W'(1);
                    if (cnt_q == COUNT_W'(1))
                        state_d = S_CMP;
                end
            end
            S_CMP: begin
                done_d  = 1'b1;
                pass_d  = (misr_q == GOLDEN);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rsp.RESP_READY = (state_q == S_RUN);
    assign BUSY           = (state_q != S_IDLE);
    assign DONE           = done_q;
    assign PASS           = pass_q;
    assign SIGNATURE      = misr_q;
endmodule

// File: tb/tb_misr_response_analyzer.sv
// Randomized bench for misr_response_analyzer with a session-level model
// compared every cycle, plus literal anchors for known signatures.
module tb_misr_response_analyzer;
    localparam int               W    = 19;
    localparam int               CW   = 16;
    localparam logic [W-1:0]     POLY = 19'h00027;
    localparam logic [W-1:0]     SEED = '0;

    logic          CK = 1'b0;
    logic          RST_N = 1'b0;
    logic          START = 1'b0;
    logic [CW-1:0] NUM_PAT = '0;
    logic [W-1:0]  GOLDEN = '0;
    logic          BUSY, DONE, PASS;
    logic [W-1:0]  SIGNATURE;

    int n_tests = 0;
    int n_fail  = 0;

    misr_response_analyzer_if #(.WIDTH(W)) rif ();

    misr_response_analyzer #(.WIDTH(W), .POLY(POLY), .SEED(SEED), .COUNT_W(CW)) dut (
        .CK(CK), .RST_N(RST_N), .START(START), .NUM_PAT(NUM_PAT), .GOLDEN(GOLDEN),
        .rsp(rif), .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .SIGNATURE(SIGNATURE)
    );

    always #5 CK = ~CK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (got running, need finished)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Polynomial view of the MISR: multiply by x mod P(x), then add the response.
    function automatic logic [W-1:0] step(input logic [W-1:0] m, input logic [W-1:0] r);
        logic [W-1:0] s;
        s = m << 1;
        if (m[W-1]) s = s ^ (POLY | W'(1));
        return s ^ r;
    endfunction

    // Session model: beats still owed, a pending compare, and the result flags.
    int           m_rem;
    bit           m_cmp, m_done, m_pass;
    logic [W-1:0] m_sig;

    always @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            m_rem = 0; m_cmp = 0; m_done = 0; m_pass = 0; m_sig = SEED;
        end else if (m_cmp) begin
            m_done = 1;
            m_pass = (m_sig == GOLDEN);
            m_cmp  = 0;
        end else if (m_rem > 0) begin
            if (rif.RESP_VALID) begin
                m_sig = step(m_sig, rif.RESP);
                m_rem = m_rem - 1;
                if (m_rem == 0) m_cmp = 1;
            end
        end else if (START) begin
            m_sig  = SEED;
            m_done = 0;
            m_pass = 0;
            if (NUM_PAT == 0) m_cmp = 1;
            else m_rem = int'(NUM_PAT);
        end
    end

    always @(negedge CK) begin
        if (RST_N) begin
            check("cyc_ready", 32'(rif.RESP_READY), 32'(m_rem > 0 && !m_cmp));
            check("cyc_busy",  32'(BUSY), 32'((m_rem > 0) || m_cmp));
            check("cyc_done",  32'(DONE), 32'(m_done));
            check("cyc_pass",  32'(PASS), 32'(m_pass));
            check("cyc_sig",   32'(SIGNATURE), 32'(m_sig));
        end
    end

    // All tasks assume entry 1 time unit after a rising edge.
    task automatic tick();
        @(posedge CK); #1;
    endtask

    task automatic start_session(input int n, input logic [W-1:0] g);
        START = 1'b1; NUM_PAT = CW'(n); GOLDEN = g;
        tick();
        START = 1'b0; NUM_PAT = CW'($urandom);
    endtask

    task automatic send(input logic [W-1:0] beat, input int gap, input bit stray);
        for (int k = 0; k < gap; k++) begin
            rif.RESP_VALID = 1'b0;
            rif.RESP = W'($urandom);
            START = stray && (k == 0);
            NUM_PAT = CW'($urandom_range(1, 9));
            tick();
            START = 1'b0;
        end
        rif.RESP_VALID = 1'b1;
        rif.RESP = beat;
        tick();
        rif.RESP_VALID = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!DONE && k < 100) begin
            tick();
            k++;
        end
        check("done_in_time", 32'(DONE), 32'd1);
    endtask

    logic [W-1:0] beats[$];
    logic [W-1:0] exp_sig, gold;
    int           n;

    initial begin
        rif.RESP = '0;
        rif.RESP_VALID = 1'b0;
        #12;
        check("rst_ready", 32'(rif.RESP_READY), 32'd0);
        check("rst_busy",  32'(BUSY), 32'd0);
        check("rst_done",  32'(DONE), 32'd0);
        check("rst_pass",  32'(PASS), 32'd0);
        check("rst_sig",   32'(SIGNATURE), 32'(SEED));
        RST_N = 1'b1;
        tick();

        // Single beat, two-edge latency to DONE.
        start_session(1, 19'h00001);
        send(19'h00001, 0, 0);
        check("t1_sig", 32'(SIGNATURE), 32'h00001);
        check("t1_cmp_done0", 32'(DONE), 32'd0);
        check("t1_cmp_ready0", 32'(rif.RESP_READY), 32'd0);
        tick();
        check("t1_done", 32'(DONE), 32'd1);
        check("t1_pass", 32'(PASS), 32'd1);

        start_session(2, 19'h00003);
        send(19'h00001, 0, 0);
        send(19'h00000, 0, 0);
        wait_done();
        check("t2_sig", 32'(SIGNATURE), 32'h00002);
        check("t2_pass", 32'(PASS), 32'd0);

        // MSB shifted out folds back through the taps.
        start_session(2, 19'h00027);
        send(19'h40000, 0, 0);
        check("t3_mid", 32'(SIGNATURE), 32'h40000);
        send(19'h00000, 0, 0);
        wait_done();
        check("t3_sig", 32'(SIGNATURE), 32'h00027);
        check("t3_pass", 32'(PASS), 32'd1);

        // Gapped handshake with a stray START mid-RUN: beats 1,2,4 -> 1,0,4.
        start_session(3, 19'h00004);
        send(19'h00001, 0, 0);
        send(19'h00002, 2, 1);
        send(19'h00004, 1, 0);
        check("t4_cmp_ready", 32'(rif.RESP_READY), 32'd0);
        check("t4_cmp_busy", 32'(BUSY), 32'd1);
        tick();
        check("t4_done", 32'(DONE), 32'd1);
        check("t4_sig", 32'(SIGNATURE), 32'h00004);
        check("t4_pass", 32'(PASS), 32'd1);
        tick();
        check("t4_idle_ready", 32'(rif.RESP_READY), 32'd0);

        // Zero-length session compares SEED directly.
        rif.RESP_VALID = 1'b1;
        start_session(0, 19'h00000);
        check("t5_ready", 32'(rif.RESP_READY), 32'd0);
        check("t5_done0", 32'(DONE), 32'd0);
        tick();
        rif.RESP_VALID = 1'b0;
        check("t5_done", 32'(DONE), 32'd1);
        check("t5_pass", 32'(PASS), 32'd1);

        // Asynchronous reset mid-RUN, then a clean 4-beat run: 1,2,3,4 -> 2.
        start_session(4, 19'h00002);
        send(19'h00007, 0, 0);
        #2 RST_N = 1'b0;
        #1;
        check("t6_rst_busy", 32'(BUSY), 32'd0);
        check("t6_rst_ready", 32'(rif.RESP_READY), 32'd0);
        check("t6_rst_done", 32'(DONE), 32'd0);
        check("t6_rst_sig", 32'(SIGNATURE), 32'(SEED));
        @(posedge CK); #2 RST_N = 1'b1;
        tick();
        check("t6_idle_busy", 32'(BUSY), 32'd0);
        start_session(4, 19'h00002);
        send(19'h00001, 0, 0);
        send(19'h00002, 0, 0);
        send(19'h00003, 0, 0);
        send(19'h00004, 0, 0);
        wait_done();
        check("t6_sig", 32'(SIGNATURE), 32'h00002);
        check("t6_pass", 32'(PASS), 32'd1);

        // Random sessions with gaps, stray STARTs and idle-time RESP_VALID noise.
        for (int s = 0; s < 40; s++) begin
            n = $urandom_range(0, 8);
            beats.delete();
            exp_sig = SEED;
            for (int b = 0; b < n; b++) begin
                beats.push_back(W'($urandom));
                exp_sig = step(exp_sig, beats[b]);
            end
            gold = ($urandom_range(0, 1) == 1) ? exp_sig : W'($urandom);
            start_session(n, gold);
            foreach (beats[b])
                send(beats[b], $urandom_range(0, 3), $urandom_range(0, 3) == 0);
            wait_done();
            check("rnd_sig", 32'(SIGNATURE), 32'(exp_sig));
            check("rnd_pass", 32'(PASS), 32'(gold == exp_sig));
            for (int k = 0; k < $urandom_range(0, 3); k++) begin
                rif.RESP_VALID = 1'($urandom);
                rif.RESP = W'($urandom);
                tick();
            end
            rif.RESP_VALID = 1'b0;
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
